// File: rtl/cd_timer_bank_pkg.sv
// Shared types for the countdown timer bank: command opcodes, per-channel
// FSM states and a helper for deriving the channel-index width.
// The optional auto-reload feature is enabled by defining CD_AUTORELOAD_EN.
package cd_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_START = 2'd1,
    OP_PAUSE = 2'd2,
    OP_CLEAR = 2'd3
  } cd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } cd_state_t;

  // Channel-index width; a single-channel bank still uses a 1-bit index.
  function automatic int cd_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cd_timer_bank_if.sv
// Command / read-back bundle of the countdown timer bank.
// Command handshake: cmd_valid is a one-cycle strobe sampled on every
// posedge clk_1Hz; there is no ready, every strobed command is accepted.
// Commands to channels >= CHANNELS are dropped. rd_count follows rd_ch
// combinationally. reload_en exists only when CD_AUTORELOAD_EN is defined.
// dbg_state exposes every channel FSM state for observation.
interface cd_timer_bank_if
  import cd_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 17,
  parameter int CH_W     = cd_ch_w(CHANNELS)
);

  logic                         cmd_valid;
  logic [CH_W-1:0]              cmd_ch;
  logic [1:0]                   cmd_op;
  logic [WIDTH-1:0]             cmd_value;
  logic [CH_W-1:0]              rd_ch;
  logic [WIDTH-1:0]             rd_count;
  logic [CHANNELS-1:0]          running;
  logic [CHANNELS-1:0]          expired;
  logic [CHANNELS-1:0]          done_pulse;
  logic                         any_expired;
  logic [CHANNELS-1:0][1:0]     dbg_state;
`ifdef CD_AUTORELOAD_EN
  logic [CHANNELS-1:0]          reload_en;

  modport master (
    output cmd_valid, cmd_ch, cmd_op, cmd_value, rd_ch, reload_en,
    input  rd_count, running, expired, done_pulse, any_expired, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_op, cmd_value, rd_ch, reload_en,
    output rd_count, running, expired, done_pulse, any_expired, dbg_state
  );
`else
  modport master (
    output cmd_valid, cmd_ch, cmd_op, cmd_value, rd_ch,
    input  rd_count, running, expired, done_pulse, any_expired, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_op, cmd_value, rd_ch,
    output rd_count, running, expired, done_pulse, any_expired, dbg_state
  );
`endif

endinterface

// File: rtl/cd_timer_bank_channel.sv
// One countdown channel: IDLE/PAUSE/RUN/DONE FSM plus seconds counter.
// A command addressed to this channel takes priority over the tick
// decrement in the same cycle. With CD_AUTORELOAD_EN defined, a RUN
// channel reaching zero with reload_en_i set restarts from the last
// loaded value instead of stopping.
module cd_channel
  import cd_pkg::*;
#(
  parameter int WIDTH     = 17,
  parameter int MAX_VALUE = 86399
) (
  input  logic             clk_1Hz,
  input  logic             rst,
  input  logic             cmd_hit_i,
  input  cd_op_t           op_i,
  input  logic [WIDTH-1:0] value_i,
`ifdef CD_AUTORELOAD_EN
  input  logic             reload_en_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output cd_state_t        state_o,
  output logic             running_o,
  output logic             expired_o,
  output logic             done_pulse_o
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  cd_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pulse_d;
  logic             running_q, expired_q, pulse_q;
  logic [WIDTH-1:0] clamped;
`ifdef CD_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign clamped = (value_i > MAX_W) ? MAX_W : value_i;

  // Next-state: command first, otherwise one-second decrement while running.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
`ifdef CD_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (cmd_hit_i) begin
      case (op_i)
        OP_LOAD: begin
          count_d = clamped;
`ifdef CD_AUTORELOAD_EN
          reload_d = clamped;
`endif
          if (clamped == '0)          state_d = ST_IDLE;
          else if (state_q == ST_RUN) state_d = ST_RUN;
          else                        state_d = ST_PAUSE;
        end
        OP_START: if (state_q == ST_PAUSE) state_d = ST_RUN;
        OP_PAUSE: if (state_q == ST_RUN)   state_d = ST_PAUSE;
        OP_CLEAR: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
        default: ;
      endcase
    end else if (state_q == ST_RUN) begin
      if (count_q > ONE_W) begin
        count_d = count_q - ONE_W;
      end else begin
        // Reaching zero; a zero count in RUN is treated the same way so the
        // counter can never wrap.
        pulse_d = 1'b1;
`ifdef CD_AUTORELOAD_EN
        if (reload_en_i && (reload_q != '0)) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
`else
        count_d = '0;
        state_d = ST_DONE;
`endif
      end
    end
  end

  // State, count and registered status outputs; async active-low reset.
  always_ff @(posedge clk_1Hz or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
`ifdef CD_AUTORELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_DONE);
      pulse_q   <= pulse_d;
`ifdef CD_AUTORELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  assign count_o      = count_q;
  assign state_o      = state_q;
  assign running_o    = running_q;
  assign expired_o    = expired_q;
  assign done_pulse_o = pulse_q;

endmodule

// File: rtl/cd_timer_bank.sv
// Bank of CHANNELS independent 1 Hz countdown timers sharing one command
// port. Decodes the command to a per-channel hit, instantiates the
// channels, and builds the read-back mux and the any_expired summary.
// Optional auto-reload is enabled by defining CD_AUTORELOAD_EN.
module cd_timer_bank
  import cd_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 17,
  parameter int MAX_VALUE = 86399,
  parameter int CH_W      = cd_ch_w(CHANNELS)
) (
  input  logic               clk_1Hz,
  input  logic               rst,
  cd_timer_bank_if.slave     bus
);

  logic [CHANNELS-1:0] cmd_hit;
  logic [CHANNELS-1:0] running_w;
  logic [CHANNELS-1:0] expired_w;
  logic [CHANNELS-1:0] pulse_w;
  logic [WIDTH-1:0]    count_w [CHANNELS];
  cd_state_t           state_w [CHANNELS];
  logic [WIDTH-1:0]    rd_count_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Out-of-range channel indices never match any instance.
    assign cmd_hit[i] = bus.cmd_valid && (bus.cmd_ch == CH_W'(i));

    cd_channel #(
      .WIDTH     (WIDTH),
      .MAX_VALUE (MAX_VALUE)
    ) u_ch (
      .clk_1Hz      (clk_1Hz),
      .rst          (rst),
      .cmd_hit_i    (cmd_hit[i]),
      .op_i         (cd_op_t'(bus.cmd_op)),
      .value_i      (bus.cmd_value),
`ifdef CD_AUTORELOAD_EN
      .reload_en_i  (bus.reload_en[i]),
`endif
      .count_o      (count_w[i]),
      .state_o      (state_w[i]),
      .running_o    (running_w[i]),
      .expired_o    (expired_w[i]),
      .done_pulse_o (pulse_w[i])
    );

    assign bus.dbg_state[i] = state_w[i];
  end

  // Read-back mux; unused indices read as zero.
  always_comb begin
    rd_count_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(bus.rd_ch) == i) rd_count_d = count_w[i];
    end
  end

  assign bus.rd_count    = rd_count_d;
  assign bus.running     = running_w;
  assign bus.expired     = expired_w;
  assign bus.done_pulse  = pulse_w;
  assign bus.any_expired = |expired_w;

endmodule

// File: tb/tb_cd_timer_bank.sv
// Bench for cd_timer_bank: directed scenarios followed by random commands,
// all checked every tick against a behavioural per-channel model.
module tb_cd_timer_bank;
  import cd_pkg::*;

  localparam int CH   = 5;
  localparam int W    = 17;
  localparam int MAXV = 86399;
  localparam int CHW  = cd_ch_w(CH);
`ifdef CD_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  cd_timer_bank_if #(.CHANNELS(CH), .WIDTH(W), .CH_W(CHW)) bus ();

  cd_timer_bank #(
    .CHANNELS(CH), .WIDTH(W), .MAX_VALUE(MAXV), .CH_W(CHW)
  ) dut (
    .clk_1Hz (clk),
    .rst     (rst),
    .bus     (bus)
  );

  // ---------------- model + scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int m_count  [CH];
  int m_reload [CH];
  bit m_run    [CH];
  bit m_done   [CH];
  bit m_pulse  [CH];
  bit m_ren    [CH];
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_count[i] = 0; m_reload[i] = 0; m_run[i] = 0; m_done[i] = 0; m_pulse[i] = 0;
    end
  endtask

  // One second of behaviour: the addressed channel obeys its command, every
  // other running channel counts down by one.
  task automatic model_step(input bit v, input int ch, input int op, input int val);
    int cl;
    for (int i = 0; i < CH; i++) begin
      m_pulse[i] = 0;
      if (v && ch == i) begin
        case (op)
          0: begin
            cl = (val > MAXV) ? MAXV : val;
            m_count[i] = cl; m_reload[i] = cl;
            m_run[i] = m_run[i] && (cl != 0);
            m_done[i] = 0;
          end
          1: if (!m_run[i] && !m_done[i] && m_count[i] > 0) m_run[i] = 1;
          2: m_run[i] = 0;
          default: begin m_run[i] = 0; m_done[i] = 0; m_count[i] = 0; end
        endcase
      end else if (m_run[i]) begin
        if (m_count[i] > 1) m_count[i]--;
        else begin
          m_pulse[i] = 1;
          if (AUTO && m_ren[i] && m_reload[i] > 0) m_count[i] = m_reload[i];
          else begin m_count[i] = 0; m_run[i] = 0; m_done[i] = 1; end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] er, ee, ep;
    er = 0; ee = 0; ep = 0;
    for (int i = 0; i < CH; i++) begin
      er[i] = m_run[i]; ee[i] = m_done[i]; ep[i] = m_pulse[i];
    end
    check({tag, ".running"},     32'(bus.running),     er);
    check({tag, ".expired"},     32'(bus.expired),     ee);
    check({tag, ".done_pulse"},  32'(bus.done_pulse),  ep);
    check({tag, ".any_expired"}, 32'(bus.any_expired), 32'(ee != 0));
    for (int r = 0; r < (1 << CHW); r++) begin
      bus.rd_ch = CHW'(r);
      #1;
      check($sformatf("%s.rd_count[%0d]", tag, r), 32'(bus.rd_count),
            (r < CH) ? 32'(m_count[r]) : 32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ren(input logic [CH-1:0] v);
    for (int i = 0; i < CH; i++) m_ren[i] = v[i];
`ifdef CD_AUTORELOAD_EN
    bus.reload_en = v;
`endif
  endtask

  task automatic cycle(input bit v, input int ch, input int op, input int val, input string tag);
    bus.cmd_valid = v;
    bus.cmd_ch    = CHW'(ch);
    bus.cmd_op    = 2'(op);
    bus.cmd_value = W'(val);
    model_step(v, ch, op, val);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    compare_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v, ch, op, val, sel;
    rst = 1'b0;
    bus.cmd_valid = 0; bus.cmd_ch = '0; bus.cmd_op = '0; bus.cmd_value = '0; bus.rd_ch = '0;
    set_ren('0);
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b1;

    // ch0: load 3, start, count 3,2,1,0 with a single pulse, expired sticks
    cycle(1, 0, 0, 3, "t1_load");
    cycle(1, 0, 1, 0, "t1_start");
    check("t1_running0", 32'(bus.running[0]), 32'd1);
    exp_q.push_back(W'(2)); exp_q.push_back(W'(1));
    exp_q.push_back(W'(0)); exp_q.push_back(W'(0));
    for (int k = 0; k < 4; k++) begin
      idle(1, "t1_tick");
      bus.rd_ch = '0; #1;
      check("t1_seq", 32'(bus.rd_count), 32'(exp_q.pop_front()));
    end
    check("t1_expired0", 32'(bus.expired[0]), 32'd1);

    // ch1: over-range load is clamped, channel parks in PAUSE
    cycle(1, 1, 0, 100000, "t2_clamp");
    bus.rd_ch = CHW'(1); #1;
    check("t2_clamp_value", 32'(bus.rd_count), 32'd86399);

    // ch2: run, pause for 3 ticks, resume
    cycle(1, 2, 0, 10, "t3_load");
    cycle(1, 2, 1, 0, "t3_start");
    idle(2, "t3_run");
    cycle(1, 2, 2, 0, "t3_pause");
    idle(3, "t3_hold");
    cycle(1, 2, 1, 0, "t3_resume");
    idle(3, "t3_run2");

    // ch0: reload while running overrides the decrement; clear at 1
    cycle(1, 0, 0, 5, "t4_load");
    cycle(1, 0, 1, 0, "t4_start");
    cycle(1, 0, 0, 20, "t4_reload");
    bus.rd_ch = '0; #1;
    check("t4_reload_value", 32'(bus.rd_count), 32'd20);
    for (int k = 0; k < 40 && m_count[0] != 1; k++) idle(1, "t4_run");
    cycle(1, 0, 3, 0, "t4_clear");

    // ignored commands: START in IDLE, out-of-range channels
    cycle(1, 4, 1, 0, "t5_start_idle");
    cycle(1, 5, 0, 7, "t5_bad_ch5");
    cycle(1, 7, 3, 0, "t5_bad_ch7");

    // ch3 with auto-reload (stops in DONE when the feature is absent)
    set_ren(5'b01000);
    cycle(1, 3, 0, 2, "t6_load");
    cycle(1, 3, 1, 0, "t6_start");
    idle(6, "t6_wrap");
    set_ren('0);

    // asynchronous reset while every channel is running
    for (int i = 0; i < CH; i++) begin
      cycle(1, i, 0, 50, "t7_load");
      cycle(1, i, 1, 0, "t7_start");
    end
    idle(2, "t7_run");
    @(posedge clk);
    #4;
    rst = 1'b0;
    #1;
    model_reset();
    check("t7_rst_running",    32'(bus.running),     32'd0);
    check("t7_rst_expired",    32'(bus.expired),     32'd0);
    check("t7_rst_done_pulse", 32'(bus.done_pulse),  32'd0);
    check("t7_rst_any",        32'(bus.any_expired), 32'd0);
    @(negedge clk);
    compare_all("t7_in_reset");
    rst = 1'b1;
    idle(2, "t7_after");

    // random commands
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      ch  = $urandom_range(0, 7);
      op  = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      if (sel < 7)      val = $urandom_range(0, 6);
      else if (sel < 9) val = $urandom_range(86390, 131071);
      else              val = 0;
      if ($urandom_range(0, 15) == 0) set_ren(CH'($urandom_range(0, 31)));
      cycle(v[0], ch, op, val, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #(40 * 20000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit");
  end

endmodule
